alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational datapath ALU. Accepts one operation per transfer on a valid/ready input port and returns a registered result with a zero flag on a valid/ready output port. Single-cycle logic, arithmetic, shift and compare ops complete in one cycle. Optional iterative multiply/divide ops take WIDTH+1 cycles. Sits between the decode/issue stage and writeback in the multi-cycle core.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_muldiv.sv | 72 +++++++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode/state definitions for the handshaked sequential ALU.
// The iterative-op helper is meaningful only when ALU_SEQ_MULDIV_EN is defined.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010,
        OP_XOR  = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_SLTU = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiply (low WIDTH bits) and restoring unsigned divide.
// A start pulse latches operands; done is high on the final step, result is valid after it.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] opb_q;
    logic             mul_q;
    logic             div_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // rem_q doubles as the product accumulator; quo_q as the multiplier shift register.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, opb_q});
        trial   = shifted[WIDTH-1:0] - opb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            opb_q <= '0;
            mul_q <= 1'b0;
            div_q <= 1'b0;
        end else if (start) begin
            cnt_q <= CW'(WIDTH);
            rem_q <= '0;
            mul_q <= (op == OP_MUL);
            div_q <= (op == OP_DIVU);
            quo_q <= (op == OP_MUL) ? b : a;
            opb_q <= (op == OP_MUL) ? a : b;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (mul_q) begin
                if (quo_q[0]) rem_q <= rem_q + opb_q;
                quo_q <= quo_q >> 1;
                opb_q <= opb_q << 1;
            end else if (fits) begin
                rem_q <= trial;
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    assign done   = (cnt_q == CW'(1));
    assign result = div_q ? quo_q : rem_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and zero flag; single-cycle ops issue at full rate.
// Define ALU_SEQ_MULDIV_EN to compile in the iterative MUL/DIVU/REMU path.
//
//   state | meaning
//   IDLE  | accepting ops when the output slot is empty or being taken
//   ITER  | iterative engine stepping, one bit per cycle
//   DONE  | engine finished, result loaded into the output slot
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign shamt    = in2[SHW-1:0];
    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        case (op_e'(op))
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_XOR:  alu_res = in1 ^ in2;
            OP_NOR:  alu_res = ~(in1 | in2);
            OP_SLL:  alu_res = in1 << shamt;
            OP_SRL:  alu_res = in1 >> shamt;
            OP_SRA:  alu_res = $signed(in1) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (op_e'(op)),
        .a      (in1),
        .b      (in2),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = alu_res;
        md_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_iter_op(op_e'(op))) begin
                        md_start = 1'b1;
                        state_d  = ITER;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ITER: if (md_done) state_d = DONE;
            DONE: begin
                load     = 1'b1;
                load_val = md_result;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == ITER);
`else
    always_comb begin
        state_d  = IDLE;
        load     = accept;
        load_val = alu_res;
    end

    assign busy = 1'b0;
`endif

    // The slot is guaranteed empty or being taken whenever load fires, so no data is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_valid <= 1'b1;
                result    <= load_val;
                zero_flag <= (load_val == '0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=32); adapts to ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero_flag;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_flag (zero_flag),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (o)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a << b[4:0];
            4'b0100: r = a >> b[4:0];
            4'b0101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: r = a ^ b;
            4'b1100: r = ~(a | b);
            4'b1111: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        pend.r   = exp;
        pend.z   = (exp == 32'd0);
    endtask

    task automatic pop_check();
        exp_t e;
        n_vec++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_output: observed result %h, expected no output", result);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("result", result, e.r);
            chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
        end
    endtask

    // One clock: check any output transfer at the negedge, then push on acceptance.
    task automatic tick();
        logic acc;
        @(negedge clk);
        if (out_valid && out_ready) pop_check();
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            sb_q.push_back(pend);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(output int lat, output int bcnt, output int rcnt);
        lat  = 0;
        bcnt = 0;
        rcnt = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid || lat >= 200) break;
            bcnt += int'(busy);
            rcnt += int'(in_ready);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("iter_out_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid && out_ready) pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        in1       = 32'd0;
        in2       = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero_flag", {31'd0, zero_flag}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD wraps to zero, result one cycle after acceptance
        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        tick();
        chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // back-to-back shifts and compares
        drive(OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        tick();
        drive(OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        tick();
        chk("b2b_valid_1", {31'd0, out_valid}, 32'd1);
        drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        tick();
        chk("b2b_valid_2", {31'd0, out_valid}, 32'd1);
        drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        tick();
        chk("b2b_valid_3", {31'd0, out_valid}, 32'd1);
        tick();
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // output hold with a pending op, then simultaneous take and accept
        out_ready = 1'b0;
        drive(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
        tick();
        drive(OP_OR, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_result", result, 32'h0000_00F0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("take_accept_valid", {31'd0, out_valid}, 32'd1);
        chk("take_accept_queued", sb_q.size(), 32'd1);
        tick();

`ifdef ALU_SEQ_MULDIV_EN
        begin : muldiv_steps
            int lat;
            int bc;
            int rc;
            int ov_cnt;

            drive(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
            tick();
            wait_result(lat, bc, rc);
            chk("mul_latency", lat, 32'd33);
            chk("mul_busy_cycles", bc, 32'd32);
            chk("mul_in_ready_iter", rc, 32'd0);

            drive(OP_MUL, 32'd12345, 32'd6789, 32'd83810205);
            tick();
            wait_result(lat, bc, rc);

            drive(OP_DIVU, 32'd100, 32'd7, 32'd14);
            tick();
            wait_result(lat, bc, rc);
            chk("divu_latency", lat, 32'd33);

            drive(OP_REMU, 32'd100, 32'd7, 32'd2);
            tick();
            wait_result(lat, bc, rc);

            drive(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
            tick();
            wait_result(lat, bc, rc);

            drive(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
            tick();
            wait_result(lat, bc, rc);

            drive(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF);
            tick();
            wait_result(lat, bc, rc);

            // reset in the middle of a divide
            drive(OP_DIVU, 32'd100, 32'd7, 32'd14);
            tick();
            repeat (10) tick();
            chk("mid_iter_busy", {31'd0, busy}, 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_result", result, 32'd0);
            chk("abort_zero_flag", {31'd0, zero_flag}, 32'd1);
            chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
            sb_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n  = 1'b1;
            ov_cnt = 0;
            repeat (40) begin
                @(negedge clk);
                ov_cnt += int'(out_valid);
                @(posedge clk);
                #1;
            end
            chk("abort_no_valid", ov_cnt, 32'd0);
        end
`else
        drive(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
        tick();
        chk("mul_off_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_off_busy", {31'd0, busy}, 32'd0);
        drive(OP_DIVU, 32'd100, 32'd7, 32'd0);
        tick();
        chk("divu_off_valid", {31'd0, out_valid}, 32'd1);
        drive(OP_REMU, 32'd100, 32'd7, 32'd0);
        tick();
        tick();
`endif

        drive(OP_ADD, 32'd2, 32'd3, 32'd5);
        tick();
        chk("post_reset_add_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // random single-cycle traffic with a stalling consumer
        for (int i = 0; i < 40; i++) begin
            if (!in_valid) begin
                o = 4'($urandom_range(0, 15));
                if (o inside {[4'd8:4'd10]}) o = 4'b1101;
                a = $urandom;
                b = (i % 5 == 0) ? a : $urandom;
                drive(o, a, b, model(o, a, b));
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        k = 0;
        while ((sb_q.size() != 0 || in_valid) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
